// File: rtl/regfile_bypass_sb.sv
// Parametrised register file with byte-enable writes, write-to-read bypass,
// a per-register pending scoreboard and a sequential clear engine.
module regfile_bypass_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   rd_addr1,
  input  logic [ADDR_W-1:0]   rd_addr2,
  output logic [DATA_W-1:0]   rd_data1,
  output logic [DATA_W-1:0]   rd_data2,
  output logic                rd_pend1,
  output logic                rd_pend2,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                wr_retire,
  input  logic                iss_en,
  input  logic [ADDR_W-1:0]   iss_addr,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                clr_done
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_W;
  localparam int unsigned BE_W     = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_busy;
  logic                r_done;
  logic [DATA_W-1:0]   r_mem [NUM_REGS];
  logic [NUM_REGS-1:0] r_pend;

  logic                w_wr_ok;
  logic                w_wr_store;
  logic                w_ret_hit;
  logic                w_iss_ok;
  logic [DATA_W-1:0]   w_wr_mask;
  logic [DATA_W-1:0]   w_wr_merged;
  logic [NUM_REGS-1:0] w_pend_nxt;

  // The clear engine owns the array while busy; all external updates are dropped.
  assign w_wr_ok    = wr_en & ~r_busy;
  assign w_wr_store = w_wr_ok & ~(ZERO_REG && (wr_addr == '0));
  assign w_ret_hit  = w_wr_ok & wr_retire;
  assign w_iss_ok   = iss_en & ~r_busy;

  always_comb begin
    w_wr_mask = '0;
    for (int unsigned b = 0; b < BE_W; b++) begin
      w_wr_mask[8*b +: 8] = {8{wr_be[b]}};
    end
  end

  assign w_wr_merged = (r_mem[wr_addr] & ~w_wr_mask) | (wr_data & w_wr_mask);

  always_comb begin
    rd_data1 = r_mem[rd_addr1];
    if (w_wr_ok && (rd_addr1 == wr_addr)) rd_data1 = w_wr_merged;
    if (ZERO_REG && (rd_addr1 == '0))     rd_data1 = '0;

    rd_data2 = r_mem[rd_addr2];
    if (w_wr_ok && (rd_addr2 == wr_addr)) rd_data2 = w_wr_merged;
    if (ZERO_REG && (rd_addr2 == '0))     rd_data2 = '0;
  end

  // Issue wins over retire so an issue/retire pair on one index stays pending.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_ret_hit) w_pend_nxt[wr_addr]  = 1'b0;
    if (w_iss_ok)  w_pend_nxt[iss_addr] = 1'b1;
    if (ZERO_REG)  w_pend_nxt[0]        = 1'b0;
  end

  assign rd_pend1 = r_pend[rd_addr1] & ~(w_ret_hit & (wr_addr == rd_addr1));
  assign rd_pend2 = r_pend[rd_addr2] & ~(w_ret_hit & (wr_addr == rd_addr2));

  assign clr_busy = r_busy;
  assign clr_done = r_done;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_mem[ADDR_W'(i)] <= '0;
      end
      r_pend  <= '0;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      if (w_wr_store) r_mem[wr_addr] <= w_wr_merged;

      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (clr_req) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_mem[r_cnt]  <= '0;
          r_pend[r_cnt] <= 1'b0;
          r_cnt         <= r_cnt + 1'b1;
          if (r_cnt == LAST_IDX) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Self-checking bench for regfile_bypass_sb: directed plan steps followed by
// random traffic, all compared against an array-based reference model.
`timescale 1ns/1ps
module tb_regfile_bypass_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] rd_addr1, rd_addr2, wr_addr, iss_addr;
  logic [DW-1:0] rd_data1, rd_data2, wr_data;
  logic          rd_pend1, rd_pend2;
  logic          wr_en, wr_retire, iss_en, clr_req;
  logic [BW-1:0] wr_be;
  logic          clr_busy, clr_done;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  // Reference model state
  logic [DW-1:0] m_mem  [NR];
  bit            m_pend [NR];
  bit            m_busy;
  bit            m_done;
  int            m_cnt;

  always #5 clk = ~clk;

  regfile_bypass_sb #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .ZERO_REG(1'b1)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2),
    .rd_pend1 (rd_pend1),
    .rd_pend2 (rd_pend2),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_be    (wr_be),
    .wr_data  (wr_data),
    .wr_retire(wr_retire),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done)
  );

  function automatic logic [DW-1:0] merged(input logic [DW-1:0] old_v,
                                           input logic [DW-1:0] new_v,
                                           input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old_v;
    for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (!m_busy && wr_en && (a == wr_addr)) return merged(m_mem[a], wr_data, wr_be);
    return m_mem[a];
  endfunction

  function automatic logic exp_pend(input logic [AW-1:0] a);
    return m_pend[a] && !(!m_busy && wr_en && wr_retire && (a == wr_addr));
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare all outputs with the model mid-cycle, away from the rising edge.
  task automatic settle();
    @(negedge clk);
    chk("rd_data1", rd_data1, exp_rd(rd_addr1));
    chk("rd_data2", rd_data2, exp_rd(rd_addr2));
    chk("rd_pend1", 32'(rd_pend1), 32'(exp_pend(rd_addr1)));
    chk("rd_pend2", 32'(rd_pend2), 32'(exp_pend(rd_addr2)));
    chk("clr_busy", 32'(clr_busy), 32'(m_busy));
    chk("clr_done", 32'(clr_done), 32'(m_done));
  endtask

  // Advance the model by one rising edge using the inputs held across it.
  task automatic tick();
    bit was_done;
    @(posedge clk);
    if (!reset) begin
      for (int i = 0; i < NR; i++) begin
        m_mem[i]  = '0;
        m_pend[i] = 1'b0;
      end
      m_busy = 1'b0;
      m_done = 1'b0;
      m_cnt  = 0;
    end else if (m_busy) begin
      m_mem[m_cnt]  = '0;
      m_pend[m_cnt] = 1'b0;
      m_cnt++;
      if (m_cnt == NR) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else begin
      was_done = m_done;
      m_done   = 1'b0;
      if (wr_en && wr_addr != 0) m_mem[wr_addr] = merged(m_mem[wr_addr], wr_data, wr_be);
      if (wr_en && wr_retire) m_pend[wr_addr] = 1'b0;
      if (iss_en && iss_addr != 0) m_pend[iss_addr] = 1'b1;
      if (clr_req && !was_done) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_retire = 1'b0; iss_en = 1'b0; clr_req = 1'b0;
    wr_be = '0; wr_data = '0; wr_addr = '0; iss_addr = '0;
  endtask

  task automatic read_all();
    idle_inputs();
    for (int i = 0; i < NR / 2; i++) begin
      rd_addr1 = AW'(i);
      rd_addr2 = AW'(i + NR / 2);
      settle();
      tick();
    end
  endtask

  int n_busy_seen;
  int done_at;
  int n_done_seen;

  initial begin
    for (int i = 0; i < NR; i++) begin
      m_mem[i]  = 'x;
      m_pend[i] = 1'b0;
    end
    m_busy = 1'b0; m_done = 1'b0; m_cnt = 0;
    idle_inputs();
    rd_addr1 = '0; rd_addr2 = '0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    read_all();

    // Full write with same-cycle bypass, then read from storage
    wr_en = 1'b1; wr_addr = 5'd5; wr_be = 4'hF; wr_data = 32'hDEADBEEF; rd_addr1 = 5'd5;
    settle();
    chk("t1_bypass", rd_data1, 32'hDEADBEEF);
    tick();
    wr_en = 1'b0;
    settle();
    chk("t1_stored", rd_data1, 32'hDEADBEEF);
    tick();

    // Partial byte-enable write
    wr_en = 1'b1; wr_addr = 5'd5; wr_be = 4'b0101; wr_data = 32'h11223344;
    settle();
    chk("t2_bypass", rd_data1, 32'hDE22BE44);
    tick();
    wr_en = 1'b0;
    settle();
    chk("t2_stored", rd_data1, 32'hDE22BE44);
    tick();

    // Register zero is hardwired
    wr_en = 1'b1; wr_addr = 5'd0; wr_be = 4'hF; wr_data = 32'hFFFFFFFF; rd_addr2 = 5'd0;
    settle();
    chk("t3_r0_bypass", rd_data2, 32'h0);
    tick();
    wr_en = 1'b0; iss_en = 1'b1; iss_addr = 5'd0; rd_addr1 = 5'd0;
    settle();
    chk("t3_r0_after", rd_data2, 32'h0);
    tick();
    iss_en = 1'b0;
    settle();
    chk("t3_r0_pend", 32'(rd_pend1), 32'd0);
    tick();

    // Scoreboard: issue, same-cycle retire visibility, issue+retire collision
    iss_en = 1'b1; iss_addr = 5'd7; rd_addr1 = 5'd7;
    settle();
    tick();
    iss_en = 1'b0;
    settle();
    chk("t4_pend_set", 32'(rd_pend1), 32'd1);
    tick();
    wr_en = 1'b1; wr_retire = 1'b1; wr_addr = 5'd7; wr_be = '0;
    settle();
    chk("t4_retire_same", 32'(rd_pend1), 32'd0);
    tick();
    iss_en = 1'b1; iss_addr = 5'd9; wr_addr = 5'd9; rd_addr2 = 5'd9;
    settle();
    tick();
    idle_inputs();
    settle();
    chk("t4_iss_ret_collide", 32'(rd_pend2), 32'd1);
    tick();

    // Fill, mark pending, clear; writes during busy are dropped
    for (int i = 1; i < NR; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_be = 4'hF; wr_data = $urandom | 32'h1;
      iss_en = (i % 4 == 0); iss_addr = AW'(i);
      rd_addr1 = AW'(i); rd_addr2 = AW'(NR - i);
      settle();
      tick();
    end
    idle_inputs();
    clr_req = 1'b1;
    settle();
    tick();
    clr_req = 1'b0;
    n_busy_seen = 0; done_at = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k >= 5 && k <= 20) begin
        wr_en = 1'b1; wr_addr = 5'd2; wr_be = 4'hF; wr_data = 32'hA5A5A5A5;
        iss_en = 1'b1; iss_addr = 5'd3; clr_req = 1'b1;
      end else begin
        idle_inputs();
      end
      rd_addr1 = 5'd2; rd_addr2 = 5'd3;
      settle();
      if (clr_busy) n_busy_seen++;
      if (clr_done && done_at == 0) done_at = k;
      tick();
      if (k == 32) idle_inputs();
    end
    chk("t5_busy_cycles", 32'(n_busy_seen), 32'd32);
    chk("t5_done_cycle", 32'(done_at), 32'd33);
    read_all();

    // Reset in the middle of a clear
    for (int i = 1; i < 6; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i * 5); wr_be = 4'hF; wr_data = $urandom | 32'h1;
      settle();
      tick();
    end
    idle_inputs();
    clr_req = 1'b1;
    settle();
    tick();
    clr_req = 1'b0;
    for (int k = 1; k < 10; k++) begin
      settle();
      tick();
    end
    reset = 1'b0;
    settle();
    tick();
    reset = 1'b1;
    settle();
    chk("t6_busy_after_reset", 32'(clr_busy), 32'd0);
    tick();
    n_done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      rd_addr1 = AW'(k % NR); rd_addr2 = AW'((k * 7) % NR);
      settle();
      if (clr_done) n_done_seen++;
      tick();
    end
    chk("t6_no_done", 32'(n_done_seen), 32'd0);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      reset     = ($urandom_range(0, 99) != 0);
      wr_en     = ($urandom_range(0, 2) != 0);
      wr_retire = ($urandom_range(0, 1) != 0);
      wr_addr   = AW'($urandom_range(0, NR - 1));
      wr_be     = BW'($urandom_range(0, 15));
      wr_data   = $urandom;
      iss_en    = ($urandom_range(0, 2) == 0);
      iss_addr  = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, NR - 1));
      clr_req   = ($urandom_range(0, 59) == 0);
      rd_addr1  = ($urandom_range(0, 1) != 0) ? wr_addr : AW'($urandom_range(0, NR - 1));
      rd_addr2  = ($urandom_range(0, 2) == 0) ? iss_addr : AW'($urandom_range(0, NR - 1));
      settle();
      tick();
    end
    reset = 1'b1;
    for (int k = 0; k < 40; k++) begin
      idle_inputs();
      settle();
      tick();
    end
    read_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_bypass_sb.md
Name: regfile_bypass_sb

Overview:
Parametrised successor to the 32x32 pipeline register file. Adds configurable width and depth, byte-enable writes and write-to-read bypass, so the decode stage sees same-cycle writeback data. Also adds a per-register pending scoreboard for hazard detection and a sequential clear engine that zeroes all registers without a global reset. Sits between the decode stage (read/issue) and the writeback stage (write/retire).

Parameters:
DATA_W, 32, register width in bits; must be a multiple of 8.
ADDR_W, 5, register index width; NUM_REGS = 2**ADDR_W.
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and pending marks; 0 = register 0 is ordinary.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous active-low reset.
rd_addr1  in  ADDR_W  read port 1 index.
rd_addr2  in  ADDR_W  read port 2 index.
rd_data1  out  DATA_W  read port 1 data (combinational, bypassed).
rd_data2  out  DATA_W  read port 2 data (combinational, bypassed).
rd_pend1  out  1  pending bit of rd_addr1 after same-cycle retire.
rd_pend2  out  1  pending bit of rd_addr2 after same-cycle retire.
wr_en  in  1  write strobe.
wr_addr  in  ADDR_W  write index.
wr_be  in  DATA_W/8  byte enables; bit i covers bits 8i+7:8i.
wr_data  in  DATA_W  write data.
wr_retire  in  1  with wr_en, clears pending bit of wr_addr.
iss_en  in  1  sets pending bit of iss_addr.
iss_addr  in  ADDR_W  index being issued.
clr_req  in  1  start clear engine (pulse or level).
clr_busy  out  1  clear engine active.
clr_done  out  1  one-cycle pulse when clear completes.

Behaviour:
- Reset (reset=0 at rising edge): all registers 0, all pending bits 0, FSM to IDLE, clr_busy=0, clr_done=0. Reset overrides every other input.
- Write: at the edge with wr_en=1 and clr_busy=0, bytes with wr_be[i]=1 update; other bytes hold. wr_be=0 writes nothing but still retires if wr_retire=1.
- Read: combinational. If wr_en=1, clr_busy=0 and rd_addrN==wr_addr, rd_dataN = stored value with enabled bytes replaced by wr_data (bypass). Otherwise rd_dataN = stored value.
- ZERO_REG=1: index 0 reads 0 regardless of bypass and ignores writes; pending bit 0 stays 0; rd_pendN=0 for index 0.
- Scoreboard, next pending[a] priority: iss_en hit sets it; else retire hit (wr_en & wr_retire) clears it; else it holds. Issue and retire to the same index in one cycle leave it set.
- rd_pendN = pending[rd_addrN] & ~(retire hit on rd_addrN this cycle). Same-cycle issue is not reflected until the next cycle.
- Clear FSM, states IDLE, CLEAR, DONE:
  - IDLE -> CLEAR on clr_req=1; internal counter set to 0.
  - CLEAR: each cycle zeroes register[cnt] and pending[cnt], then increments cnt. clr_busy=1. Goes to DONE after cnt = NUM_REGS-1, so it takes exactly NUM_REGS cycles.
  - DONE: clr_done=1 for one cycle, clr_busy=0, then returns to IDLE. clr_req held high in DONE is ignored; a new clear needs clr_req seen in IDLE.
  - While clr_busy=1: wr_en, iss_en and clr_req are ignored, bypass is disabled, and reads return current array contents (partially cleared).
- Reset mid-clear aborts immediately to the reset state; no clr_done pulse.
- Latency: a write is visible same cycle via bypass and from storage the next cycle. Pending set is visible the next cycle. Clear is complete NUM_REGS+1 cycles after accepting clr_req (counting the DONE cycle).

Test Plan:
1. Reset, then write r5=0xDEADBEEF with be=4'hF while rd_addr1=5 -> rd_data1=0xDEADBEEF the same cycle and on the next cycle with wr_en=0.
2. Write r5 with be=4'b0101, data 0x11223344, over 0xDEADBEEF -> r5=0xDE22BE44; a same-cycle bypass read shows 0xDE22BE44.
3. ZERO_REG=1: write r0=0xFFFFFFFF with rd_addr2=0 -> rd_data2=0 in that cycle and after; iss_en on r0 -> rd_pend=0.
4. iss_en r7 -> next cycle rd_pend1=1 for r7. wr_en+wr_retire r7 -> rd_pend1=0 the same cycle. Simultaneous iss_en r9 + retire r9 -> r9 pending=1 the next cycle.
5. Fill r1..r31 with nonzero values and set some pending bits, pulse clr_req -> clr_busy=1 for 32 cycles, clr_done pulses on cycle 33, all reads 0, all pending 0. A wr_en during busy has no effect.
6. Start a clear, drive reset=0 at cycle 10 -> next cycle clr_busy=0, all registers 0, and no clr_done pulse ever.
